// File: rtl/mips_pkg.sv
// Definitions shared by the MIPS fetch stage and the control block: fetch
// states, opcode values and instruction field positions.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;

endpackage

// File: rtl/mips_pc_next.sv
// Next-PC adder: pc + 4, plus the word-scaled sign-extended immediate when a
// branch is taken. All arithmetic wraps modulo 2^PC_W.
module mips_pc_next #(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     imm,
  input  logic            take,
  output logic [PC_W-1:0] pc_next
);

  // Work wide enough that the sign-extended, shifted immediate never loses
  // bits before the final wrap to PC_W.
  localparam int WW = PC_W + 18;

  assign pc_next = PC_W'(WW'(pc) + WW'(4)
                         + (take ? (WW'(signed'(imm)) << 2) : WW'(0)));

endmodule

// File: rtl/mips_instr_fetch.sv
// Byte-serial instruction fetch: assembles big-endian 32-bit words, holds the
// split fields until consumed, and owns the program counter.
module mips_instr_fetch
  import mips_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      byte_in,
  input  logic            byte_valid,
  output logic            byte_ready,
  output logic            fetch_req,
  output logic [PC_W-1:0] pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            branch,
  input  logic            zero,
  output logic [5:0]      opcode,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [5:0]      funct,
  output logic [15:0]     imm
);

  state_e          state;
  logic [1:0]      count;
  logic [31:0]     instr;
  logic [PC_W-1:0] pc_next;
  logic            accept;
  logic            consume;

  assign byte_ready  = (state == FETCH);
  assign fetch_req   = (state == FETCH);
  assign instr_valid = (state == HOLD);

  assign accept  = byte_valid & byte_ready;
  assign consume = instr_valid & instr_ready;

  assign opcode = instr[OPCODE_LSB +: 6];
  assign rs     = instr[RS_LSB +: 5];
  assign rt     = instr[RT_LSB +: 5];
  assign rd     = instr[RD_LSB +: 5];
  assign funct  = instr[FUNCT_LSB +: 6];
  assign imm    = instr[IMM_LSB +: 16];

  mips_pc_next #(
    .PC_W (PC_W)
  ) u_pc_next (
    .pc      (pc),
    .imm     (imm),
    .take    (branch & zero),
    .pc_next (pc_next)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the instruction register is small enough to reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      instr <= '0;
      pc    <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          count <= '0;
        end
        FETCH: begin
          if (accept) begin
            // Byte slot 3-count is ~count for a 2-bit counter: MSB byte first.
            instr[{~count, 3'b000} +: 8] <= byte_in;
            count <= count + 2'd1;
            if (count == 2'd3) state <= HOLD;
          end
        end
        HOLD: begin
          if (consume) begin
            pc    <= pc_next;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mips_instr_fetch.md
# mips_instr_fetch

Byte-serial instruction fetch and field-split stage for the single-cycle MIPS datapath. It assembles each 32-bit instruction from four big-endian byte transfers and holds the decoded fields (opcode, rs, rt, rd, funct, imm) for the downstream control block. It also owns the program counter, advancing it by 4 or to the branch target when Branch and the ALU zero flag are both set.

## Interface
Parameters:
- PC_W, 16, program counter width in bits (≥ 8)
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- byte_in  in  8  instruction byte from external memory, MSB byte first
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  stage accepts a byte this cycle
- fetch_req  out  1  pc is a valid fetch address
- pc  out  PC_W  address of the instruction being fetched/held
- instr_valid  out  1  decoded fields are valid
- instr_ready  in  1  downstream consumes the instruction
- branch  in  1  Branch from control, sampled at consume
- zero  in  1  ALU zero flag, sampled at consume
- opcode  out  6  instr[31:26]
- rs  out  5  instr[25:21]
- rt  out  5  instr[20:16]
- rd  out  5  instr[15:11]
- funct  out  6  instr[5:0]
- imm  out  16  instr[15:0]

## Operation
- State machine IDLE → FETCH → HOLD → FETCH …; IDLE is entered only from reset.
- IDLE: lasts one cycle after rst_n deasserts, then goes to FETCH with byte count 0.
- FETCH: byte_ready = fetch_req = 1. A byte is accepted when byte_valid & byte_ready; it is shifted into instr[31:0] at position 3-count, and count increments. Count holds while byte_valid is low. On the 4th accepted byte, go to HOLD with count 0.
- HOLD: instr_valid = 1 and byte_ready = 0. byte_valid is ignored and no byte is consumed. Fields are stable until consumed.
- Consume: instr_valid & instr_ready. pc_next = pc + 4 + ((branch & zero) ? sext(imm) << 2 : 0), all arithmetic mod 2^PC_W. sext extends to PC_W and the shift result is truncated. Then go to FETCH.
- pc is constant throughout FETCH and HOLD. It changes only on a consume.
- Field outputs are plain slices of the instruction register. There is no opcode legality check.
- Reset values: state IDLE, count 0, instruction register 0 (all fields 0), pc RESET_PC, byte_ready 0, fetch_req 0, instr_valid 0.
- Reset mid-operation: partially assembled bytes are discarded immediately (asynchronous) and pc returns to RESET_PC.

## Timing
- byte_ready, fetch_req and instr_valid are registered-state decodes with no combinational path from inputs.
- instr_valid rises the cycle after the 4th byte handshake.
- Back-to-back case, with byte_valid and instr_ready held high: 4 byte cycles + 1 HOLD cycle = 5 cycles per instruction.
- New pc is visible the cycle after consume, coincident with byte_ready = 1.
- branch and zero matter only in the consume cycle. They are don't-care otherwise.

## Structure
- Shared package mips_pkg:
  - state enum (IDLE, FETCH, HOLD)
  - opcode constants OP_RTYPE 6'h00, OP_LW 6'h23, OP_SW 6'h2B, OP_BEQ 6'h04, so control and fetch share one definition
  - field bit-position constants
- One combinational sub-module, mips_pc_next: pc, imm, take → next pc. It is reused later by a pipelined fetch.

## Test plan
- Reset, then bytes 8C 22 00 04 with consume → instr_valid 1 cycle after the 4th byte; opcode 0x23, rs 1, rt 2, imm 0x0004, pc 0x0000; pc 0x0004 after consume.
- R-type bytes 00 22 18 20 → opcode 0x00, rs 1, rt 2, rd 3, funct 0x20; branch=0 at consume → pc +4.
- beq at pc 0x0010 with imm 0xFFFF:
  - branch=1, zero=1 → next pc 0x0010
  - branch=1, zero=0 → 0x0014
  - branch=0, zero=1 → 0x0014
- byte_valid gaps of 1–3 cycles and instr_ready low for 3 cycles in HOLD → fields unchanged, byte_ready 0, extra bytes on byte_in not consumed, next instruction correct.
- rst_n low after 2 bytes accepted → outputs at reset values in the same cycle; after release, one IDLE cycle, then 4 new bytes form an instruction unpolluted by old bytes at pc RESET_PC.
- PC_W=16, pc 0xFFFC, non-branch consume → pc 0x0000; branch with imm 0x0001 at 0xFFF8 → 0x0000.
